// File: rtl/alu_issue.sv
// Single-issue MIPS R-type sequencer driving an external combinational ALU.
// Holds a 32x32 register file; each instruction walks IDLE -> EXEC -> WB.
module alu_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] DR1,
    output logic [31:0] DR2,
    output logic [2:0]  ALUControl,
    input  logic [31:0] ALUOutput,
    output logic        done,
    output logic        illegal,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] result_q, result_d;
    logic [31:0] rf_q [32];

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [2:0]  op_ctrl;
    logic        op_legal;
    logic        rf_we;
    logic        shamt_unused;

    assign opcode       = instr_q[31:26];
    assign rs           = instr_q[25:21];
    assign rt           = instr_q[20:16];
    assign rd           = instr_q[15:11];
    assign funct        = instr_q[5:0];
    assign shamt_unused = ^instr_q[10:6];

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        op_ctrl  = 3'b000;
        op_legal = 1'b0;
        if (opcode == 6'd0) begin
            op_legal = 1'b1;
            case (funct)
                6'h20:   op_ctrl = 3'b001;
                6'h22:   op_ctrl = 3'b010;
                6'h2A:   op_ctrl = 3'b011;
                6'h24:   op_ctrl = 3'b100;
                6'h25:   op_ctrl = 3'b101;
                6'h26:   op_ctrl = 3'b110;
                6'h27:   op_ctrl = 3'b111;
                default: op_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Illegal instructions retire with a zero result whatever the ALU returns.
                result_d = op_legal ? ALUOutput : 32'd0;
                state_d  = WB;
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            instr_q  <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            result_q <= result_d;
        end
    end

    assign rf_we = (state_q == WB) && op_legal && (rd != 5'd0);

    // NOTE: the register file must come out of reset all-zero, so it is cleared explicitly and therefore maps to flops, not a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (rf_we) begin
            rf_q[rd] <= result_q;
        end
    end

    always_comb begin
        instr_ready = (state_q == IDLE);
        DR1         = 32'd0;
        DR2         = 32'd0;
        ALUControl  = 3'b000;
        done        = 1'b0;
        illegal     = 1'b0;
        wb_addr     = 5'd0;
        wb_data     = 32'd0;
        if (state_q == EXEC) begin
            DR1        = (rs == 5'd0) ? 32'd0 : rf_q[rs];
            DR2        = (rt == 5'd0) ? 32'd0 : rf_q[rt];
            ALUControl = op_ctrl;
        end
        if (state_q == WB) begin
            done    = 1'b1;
            illegal = ~op_legal;
            wb_addr = rd;
            wb_data = result_q;
        end
    end

    assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : rf_q[dbg_raddr];

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: stimulus pushes expected retirements from an
// architectural register-file model; a monitor pops and compares on every done pulse.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] DR1, DR2;
    logic [2:0]  ALUControl;
    logic [31:0] ALUOutput;
    logic        done, illegal;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    alu_issue dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .DR1         (DR1),
        .DR2         (DR2),
        .ALUControl  (ALUControl),
        .ALUOutput   (ALUOutput),
        .done        (done),
        .illegal     (illegal),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .dbg_raddr   (dbg_raddr),
        .dbg_rdata   (dbg_rdata)
    );

    always #5 clk = ~clk;

    // External ALU; code 000 returns garbage so an ungated illegal result shows up.
    always_comb begin
        case (ALUControl)
            3'b001:  ALUOutput = DR1 + DR2;
            3'b010:  ALUOutput = DR1 - DR2;
            3'b011:  ALUOutput = ($signed(DR1) < $signed(DR2)) ? 32'd1 : 32'd0;
            3'b100:  ALUOutput = DR1 & DR2;
            3'b101:  ALUOutput = DR1 | DR2;
            3'b110:  ALUOutput = DR1 ^ DR2;
            3'b111:  ALUOutput = ~(DR1 | DR2);
            default: ALUOutput = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    int          done_cycs[$];
    logic [31:0] model_rf [32];
    logic [5:0]  functs [7] = '{6'h20, 6'h22, 6'h2A, 6'h24, 6'h25, 6'h26, 6'h27};
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] f);
        return {6'd0, rs, rt, rd, 5'd0, f};
    endfunction

    // Architectural effect of one instruction on the model register file.
    task automatic model_exec(input logic [31:0] w, output exp_t e, output logic [2:0] ctrl);
        logic [31:0] a, b, r;
        logic        ill;
        a    = model_rf[w[25:21]];
        b    = model_rf[w[20:16]];
        r    = 32'd0;
        ill  = 1'b0;
        ctrl = 3'b000;
        if (w[31:26] != 6'd0) ill = 1'b1;
        else begin
            case (w[5:0])
                6'h20: begin r = a + b;  ctrl = 3'd1; end
                6'h22: begin r = a - b;  ctrl = 3'd2; end
                6'h2A: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; ctrl = 3'd3; end
                6'h24: begin r = a & b;  ctrl = 3'd4; end
                6'h25: begin r = a | b;  ctrl = 3'd5; end
                6'h26: begin r = a ^ b;  ctrl = 3'd6; end
                6'h27: begin r = ~(a | b); ctrl = 3'd7; end
                default: ill = 1'b1;
            endcase
        end
        if (ill) r = 32'd0;
        e.rd   = w[15:11];
        e.data = r;
        e.ill  = ill;
        if (!ill && w[15:11] != 5'd0) model_rf[w[15:11]] = r;
    endtask

    // Called on a negedge; holds instr_valid high with junk until IDLE, then offers w.
    // Returns on the negedge inside EXEC, with instr_valid still high and junk on instr.
    task automatic issue(input logic [31:0] w);
        exp_t        e;
        logic [2:0]  ctrl;
        logic [31:0] a, b;
        int          budget;
        budget      = 0;
        instr_valid = 1'b1;
        while (!instr_ready && budget < 20) begin
            instr = $urandom;
            @(negedge clk);
            budget++;
        end
        check("issue_ready", {31'd0, instr_ready}, 32'd1);
        instr = w;
        a = model_rf[w[25:21]];
        b = model_rf[w[20:16]];
        model_exec(w, e, ctrl);
        exp_q.push_back(e);
        @(negedge clk);
        instr = $urandom;
        check("exec_dr1", DR1, a);
        check("exec_dr2", DR2, b);
        check("exec_ctrl", {29'd0, ALUControl}, {29'd0, ctrl});
    endtask

    task automatic drain();
        int budget;
        budget      = 0;
        instr_valid = 1'b0;
        while (exp_q.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_rf(input logic [4:0] idx, input logic [31:0] expv);
        dbg_raddr = idx;
        #1;
        check($sformatf("rf[%0d]", idx), dbg_rdata, expv);
    endtask

    // Scoreboard monitor: every retirement must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            done_cycs.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wb_addr", {27'd0, wb_addr}, {27'd0, e.rd});
                check("wb_data", wb_data, e.data);
                check("illegal", {31'd0, illegal}, {31'd0, e.ill});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g1, g2;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;

        // Reset with a handshake offered: the offer must be ignored.
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = rtype(5'd1, 5'd1, 5'd5, 6'h20);
        dbg_raddr   = 5'd0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_dr1", DR1, 32'd0);
        check("rst_ctrl", {29'd0, ALUControl}, 32'd0);
        reset       = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, instr_ready}, 32'd1);

        // NOR $1,$0,$0 then SUB $2,$0,$1 and ADD $3,$2,$2 back to back.
        done_cycs.delete();
        issue(rtype(5'd0, 5'd0, 5'd1, 6'h27));
        dbg_raddr = 5'd1;
        @(negedge clk);
        check("nor_done", {31'd0, done}, 32'd1);
        check("nor_wb_data", wb_data, 32'hFFFF_FFFF);
        check("rf1_prewrite", dbg_rdata, 32'd0);
        issue(rtype(5'd0, 5'd1, 5'd2, 6'h22));
        check("rf1_postwrite", dbg_rdata, 32'hFFFF_FFFF);
        issue(rtype(5'd2, 5'd2, 5'd3, 6'h20));
        drain();
        check_rf(5'd2, 32'd1);
        check_rf(5'd3, 32'd2);
        check("done_count", done_cycs.size(), 32'd3);
        g1 = (done_cycs.size() == 3) ? done_cycs[1] - done_cycs[0] : -1;
        g2 = (done_cycs.size() == 3) ? done_cycs[2] - done_cycs[1] : -1;
        check("done_gap1", g1, 32'd3);
        check("done_gap2", g2, 32'd3);

        // Write to $0 is discarded.
        issue(rtype(5'd1, 5'd1, 5'd0, 6'h20));
        drain();
        check_rf(5'd0, 32'd0);

        // Illegal opcode and illegal funct: no register changes.
        issue({6'h08, 5'd1, 5'd1, 5'd5, 5'd0, 6'h20});
        drain();
        issue(rtype(5'd1, 5'd1, 5'd6, 6'h21));
        drain();
        for (int i = 0; i < 32; i++) check_rf(i[4:0], model_rf[i]);

        // Reset during EXEC of AND $4,$1,$1 abandons it.
        issue(rtype(5'd1, 5'd1, 5'd4, 6'h24));
        instr_valid = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        #1;
        check("abort_ready", {31'd0, instr_ready}, 32'd1);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("abort_done2", {31'd0, done}, 32'd0);
        for (int i = 0; i < 32; i++) check_rf(i[4:0], 32'd0);
        @(negedge clk);

        // Random mix, junk held on instr while busy, occasional idle gaps.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(9) != 0) w[31:26] = 6'd0;
            if ($urandom_range(9) < 8)  w[5:0]   = functs[$urandom_range(6)];
            if (n < 3) w = rtype(5'd0, 5'd0, 5'(n + 7), 6'h27);
            issue(w);
            if ($urandom_range(3) == 0) drain();
        end
        drain();
        for (int i = 0; i < 32; i++) check_rf(i[4:0], model_rf[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-002 Port clk  in  1  system clock.
REQ-003 Port reset  in  1  synchronous active-high reset.
REQ-004 Port instr_valid  in  1  an instruction is offered on instr.
REQ-005 Port instr_ready  out  1  the block can accept an instruction this cycle.
REQ-006 Port instr  in  32  MIPS R-type word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct.
REQ-007 Port DR1  out  32  first ALU operand.
REQ-008 Port DR2  out  32  second ALU operand.
REQ-009 Port ALUControl  out  3  ALU operation select.
REQ-010 Port ALUOutput  in  32  combinational result returned by the external ALU.
REQ-011 Port done  out  1  one-cycle pulse: the instruction has retired.
REQ-012 Port illegal  out  1  one-cycle pulse, coincident with done: the retired instruction was unsupported.
REQ-013 Port wb_addr  out  5  destination register of the retiring instruction, valid while done=1.
REQ-014 Port wb_data  out  32  result of the retiring instruction, valid while done=1.
REQ-015 Port dbg_raddr  in  5  debug read address.
REQ-016 Port dbg_rdata  out  32  combinational read of register dbg_raddr; reads 0 for address 0.

Function
REQ-017 The block SHALL contain a 32 x 32-bit register file; register 0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-018 The FSM SHALL have the states IDLE, EXEC and WB; the reset state SHALL be IDLE.
REQ-019 instr_ready SHALL be 1 in IDLE only; a transfer occurs on an edge where instr_valid=1 and instr_ready=1; instr SHALL be latched and the state SHALL move to EXEC.
REQ-020 In EXEC, DR1=rf[rs] and DR2=rf[rt], read at the start of EXEC; ALUControl SHALL equal the decoded code; at the end of EXEC, ALUOutput SHALL be captured into a result register and the state SHALL move to WB.
REQ-021 Decode, valid only when opcode=0: funct 0x20 maps to 001 (ADD); 0x22 to 010 (SUB); 0x2A to 011 (SLT); 0x24 to 100 (AND); 0x25 to 101 (OR); 0x26 to 110 (XOR); 0x27 to 111 (NOR).
REQ-022 Any other opcode or funct value SHALL be illegal; for an illegal instruction, ALUControl SHALL be 000 in EXEC and the captured result SHALL be 0.
REQ-023 Outside EXEC, DR1, DR2 and ALUControl SHALL all be 0.
REQ-024 In WB, done=1, wb_addr=rd and wb_data=the captured result; rf[rd] SHALL be written at the end of WB if rd!=0 and the instruction is legal; the next state SHALL be IDLE.
REQ-025 In WB, illegal SHALL equal 1 for an illegal instruction, and no register SHALL be written.
REQ-026 Latency: for a handshake on edge E0, EXEC occupies the cycle after E0, WB the cycle after that, and instr_ready returns one cycle after WB; throughput is one instruction per 3 cycles.
REQ-027 Back-to-back dependency: an instruction accepted immediately after WB SHALL read the value written in that WB (no bypass is needed, since the write precedes EXEC).
REQ-028 dbg_rdata SHALL show the pre-write value during WB and the new value from the following cycle.
REQ-029 Fields shamt [10:6] SHALL be ignored; arithmetic width is 32 bits, with no overflow detection.

Reset
REQ-030 When reset=1 on an edge, the state SHALL be IDLE, all 32 registers SHALL be 0, and the captured instruction and result registers SHALL be 0; done, illegal, wb_addr and wb_data SHALL be 0, and instr_ready SHALL be 1 in the following cycle.
REQ-031 Reset asserted in EXEC or WB SHALL abandon the instruction: no register write, and no done pulse.
REQ-032 reset SHALL take priority over a simultaneous handshake; the offered instruction SHALL not be accepted.

Verification (bench models the ALU combinationally from DR1/DR2/ALUControl)
REQ-033 Issue NOR $1,$0,$0 -> EXEC shows DR1=0, DR2=0, ALUControl=111; WB shows done=1, wb_addr=1, wb_data=0xFFFFFFFF; dbg rf[1]=0xFFFFFFFF.
REQ-034 Then issue SUB $2,$0,$1 back-to-back, then ADD $3,$2,$2 -> rf[2]=0x00000001 and rf[3]=0x00000002; done pulses are spaced exactly 3 cycles apart with instr_valid held high.
REQ-035 Issue ADD $0,$1,$1 -> done=1, wb_data=0xFFFFFFFE, and rf[0] still reads 0.
REQ-036 Issue opcode=0x08, or funct=0x21 -> ALUControl=000 in EXEC, done=1 and illegal=1 in WB, and no register changes.
REQ-037 Assert reset in the EXEC cycle of AND $4,$1,$1 -> no done pulse, rf[4]=0, all registers 0, and instr_ready=1 one cycle after reset deasserts.
REQ-038 Hold instr_valid=1 during EXEC and WB with changing instr -> only the word present at the IDLE handshake is executed.
